// File: rtl/mk14_pkg.sv
// Shared constants and types for the MK14 display/keyboard block.
// Holds the decode page, matrix sizes, segment type and strobe/decode helpers.
package mk14_pkg;

    localparam logic [3:0] DISP_PAGE  = 4'hD;
    localparam int         NUM_DIGITS = 8;
    localparam int         NUM_ROWS   = 4;

    typedef logic [7:0]          seg_t;
    typedef logic [NUM_ROWS-1:0] key_t;

    // Active-low one-hot strobe for digit d.
    function automatic logic [NUM_DIGITS-1:0] digit_strobe(input logic [2:0] d);
        return ~(8'b1 << d);
    endfunction

    // A11..A8 select the page; A15..A12 and A7..A4 are don't-care mirrors.
    function automatic logic page_hit(input logic [15:0] a);
        return a[11:8] == DISP_PAGE;
    endfunction

endpackage

// File: rtl/mk14_disp_kbd_if.sv
// Core-side data bus bundle for the display/keyboard block.
// master: core drives enable/address/write strobe/data; slave: returns sel and rd_data.
interface mk14_disp_kbd_if;
    import mk14_pkg::*;

    logic        bus_en;
    logic [15:0] mem_addr;
    logic        mem_write_en;
    seg_t        mem_write_data;
    logic        sel;
    logic [7:0]  rd_data;

    modport master (
        output bus_en, mem_addr, mem_write_en, mem_write_data,
        input  sel, rd_data
    );

    modport slave (
        input  bus_en, mem_addr, mem_write_en, mem_write_data,
        output sel, rd_data
    );

endinterface

// File: rtl/kbd_debounce.sv
// Debouncer for one key-matrix column: stable state changes after N identical samples.
// Ports: clk, rst_n, sample_en (one pulse per frame), sample (synced rows), state (0=pressed).
module kbd_debounce
    import mk14_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  key_t sample,
    output key_t state
);

    localparam int             DW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0]  CNT_HIT = DW'(DEBOUNCE_SCANS);

    key_t          state_q, state_d;
    key_t          prev_q, prev_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] bump;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        bump    = '0;
        if (sample_en) begin
            prev_d = sample;
            if (sample == state_q) begin
                cnt_d = '0;
            end else begin
                // A new candidate pattern restarts the run length.
                if (cnt_q == '0 || sample != prev_q) begin
                    bump = DW'(1);
                end else begin
                    bump = cnt_q + DW'(1);
                end
                if (bump == CNT_HIT) begin
                    state_d = sample;
                    cnt_d   = '0;
                end else begin
                    cnt_d = bump;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mk14_disp_kbd.sv
// Memory-mapped 8-digit 7-segment display and 8x4 key matrix scanner.
// Ports: clk, rst_n, bus (slave: decode/write/read), seg, dig_n (active-low), row_n (async rows).
module mk14_disp_kbd
    import mk14_pkg::*;
#(
    parameter int CLOCK_FREQ_MHZ = 50,
    parameter int SCAN_US        = 1000,
    parameter int BLANK_CYCLES   = 64,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mk14_disp_kbd_if.slave        bus,
    output seg_t                  seg,
    output logic [NUM_DIGITS-1:0] dig_n,
    input  key_t                  row_n
);

    localparam int            SLOT      = CLOCK_FREQ_MHZ * SCAN_US;
    localparam int            CW        = $clog2(SLOT);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(SLOT - 2);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    seg_t                  latch_q [NUM_DIGITS];
    seg_t                  latch_d [NUM_DIGITS];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            digit_q, digit_d;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
    logic [7:0]            rd_data_q, rd_data_d;
    key_t                  row_s1_q, row_s1_d;
    key_t                  row_s2_q, row_s2_d;

    key_t                  keystate [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] col_en;
    logic                  wr_hit;
    logic                  blank_d;
    logic                  sample_en;

    assign bus.sel = page_hit(bus.mem_addr);
    assign wr_hit  = bus.sel & bus.mem_write_en & bus.bus_en
                   & ~bus.mem_addr[3];

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            latch_d[i] = latch_q[i];
        end
        if (wr_hit) begin
            latch_d[bus.mem_addr[2:0]] = bus.mem_write_data;
        end
    end

    // Outputs are computed from the next counter/digit so the
    // registered strobes line up with the slot they belong to.
    always_comb begin
        if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            digit_d = digit_q;
        end
        blank_d = cnt_d < BLANK_END;
        dig_n_d = blank_d ? '1 : digit_strobe(digit_d);
        seg_d   = blank_d ? '0 : latch_q[digit_d];
    end

    // Sample late in the slot, once the column strobe has settled
    // through the synchronizer.
    always_comb begin
        sample_en = cnt_q == SAMPLE_AT;
        col_en    = '0;
        col_en[digit_q] = sample_en;
    end

    always_comb begin
        row_s1_d = row_n;
        row_s2_d = row_s1_q;
    end

    always_comb begin
        if (bus.mem_addr[3]) begin
            rd_data_d = 8'hFF;
        end else begin
            rd_data_d = {keystate[bus.mem_addr[2:0]], 4'hF};
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_col
        kbd_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (col_en[g]),
            .sample    (row_s2_q),
            .state     (keystate[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                latch_q[i] <= '0;
            end
            cnt_q     <= '0;
            digit_q   <= '0;
            seg_q     <= '0;
            dig_n_q   <= '1;
            rd_data_q <= 8'hFF;
            row_s1_q  <= '1;
            row_s2_q  <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                latch_q[i] <= latch_d[i];
            end
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            dig_n_q   <= dig_n_d;
            rd_data_q <= rd_data_d;
            row_s1_q  <= row_s1_d;
            row_s2_q  <= row_s2_d;
        end
    end

    assign seg         = seg_q;
    assign dig_n       = dig_n_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_mk14_disp_kbd.sv
// Directed bench for mk14_disp_kbd with a scoreboard of expected values.
// Slot = 50 clocks, blank = 4, frame = 400 clocks.
module tb_mk14_disp_kbd;
    import mk14_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    seg_t       seg;
    logic [7:0] dig_n;
    key_t       row_n;
    logic       press_en = 1'b0;
    key_t       pat = 4'hF;

    always #5 clk = ~clk;

    mk14_disp_kbd_if bus ();

    mk14_disp_kbd #(
        .CLOCK_FREQ_MHZ (50),
        .SCAN_US        (1),
        .BLANK_CYCLES   (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .seg   (seg),
        .dig_n (dig_n),
        .row_n (row_n)
    );

    // Key matrix: the pressed key only pulls its row while column 4 is strobed.
    assign row_n = (press_en && !dig_n[4]) ? pat : 4'hF;

    // Clock edges since reset release: slot timebase.
    int k;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] exp_q [$];
    string      tag_q [$];
    seg_t       lat [8];

    task automatic push(input string t, input logic [7:0] v);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic pop_cmp(input logic [7:0] obs);
        logic [7:0] e;
        string      t;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                mismatched++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic check(input string t, input logic [7:0] obs,
                         input logic [7:0] e);
        push(t, e);
        pop_cmp(obs);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            input logic en);
        @(negedge clk);
        bus.mem_addr       = a;
        bus.mem_write_data = d;
        bus.mem_write_en   = 1'b1;
        bus.bus_en         = en;
        if (a[11:8] == 4'hD && en && !a[3]) lat[a[2:0]] = d;
        @(negedge clk);
        bus.mem_write_en = 1'b0;
        bus.bus_en       = 1'b1;
    endtask

    task automatic do_read(input logic [15:0] a, input string t,
                           input logic [7:0] e);
        @(negedge clk);
        bus.mem_addr = a;
        push(t, e);
        @(negedge clk);
        pop_cmp(bus.rd_data);
    endtask

    task automatic wait_mod(input int m);
        int n;
        n = 0;
        @(negedge clk);
        while (k % 400 != m && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (k % 400 != m) begin
            compared++;
            mismatched++;
            $display("FAIL wait_timeout observed=%0d expected=%0d", k % 400, m);
        end
    endtask

    // Column 4 sample has been taken once k%400 reaches 249.
    task automatic wait_sample();
        wait_mod(249);
    endtask

    task automatic check_frame();
        logic [7:0] one;
        logic [7:0] ed;
        logic [7:0] es;
        int         c;
        int         s;
        one = 8'b1;
        repeat (400) begin
            @(negedge clk);
            c  = k % 50;
            s  = (k / 50) % 8;
            ed = (c < 4) ? 8'hFF : ~(one << s);
            es = (c < 4) ? 8'h00 : lat[s];
            push("frame_dig_n", ed);
            pop_cmp(dig_n);
            push("frame_seg", es);
            pop_cmp(seg);
        end
    endtask

    initial begin
        bus.bus_en         = 1'b1;
        bus.mem_addr       = 16'h0D08;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_data = 8'h00;
        for (int i = 0; i < 8; i++) lat[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_dig_n", dig_n, 8'hFF);
        check("rst_seg", seg, 8'h00);
        check("rst_rd_data", bus.rd_data, 8'hFF);
        rst_n = 1'b1;

        // Reset asserted mid-slot while digit 2 is lit.
        wait_mod(120);
        check("pre_rst_dig_n", dig_n, 8'hFB);
        rst_n = 1'b0;
        #1;
        check("async_rst_dig_n", dig_n, 8'hFF);
        check("async_rst_seg", seg, 8'h00);
        check("async_rst_rd", bus.rd_data, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_read(16'h0D03, "rd_0d03", 8'hFF);

        // Latch writes, mirror write, ignored writes.
        do_write(16'h0D02, 8'h3F, 1'b1);
        do_write(16'h8D05, 8'h06, 1'b1);
        do_write(16'h0D0A, 8'hFF, 1'b1);
        do_write(16'h0D01, 8'h77, 1'b0);
        check_frame();

        // Steady key in column 4 row 1.
        wait_sample();
        press_en = 1'b1;
        pat      = 4'b1101;
        wait_sample();
        wait_sample();
        do_read(16'h0D04, "press_col4_pre", 8'hFF);
        do_read(16'h0D03, "press_col3_pre", 8'hFF);
        wait_sample();
        do_read(16'h0D04, "press_col4_post", 8'hDF);
        do_read(16'h0D05, "press_col5_post", 8'hFF);
        do_read(16'h0D0C, "press_a3_set", 8'hFF);

        // One-cycle read latency and decode.
        @(negedge clk);
        bus.mem_addr = 16'h0D08;
        push("rt_prev", 8'hFF);
        @(negedge clk);
        pop_cmp(bus.rd_data);
        bus.mem_addr = 16'h0D04;
        #1;
        check("rt_sel_0d04", {7'd0, bus.sel}, 8'h01);
        check("rt_not_yet", bus.rd_data, 8'hFF);
        push("rt_valid", 8'hDF);
        @(negedge clk);
        pop_cmp(bus.rd_data);
        bus.mem_addr = 16'h0C04;
        #1;
        check("sel_0c04", {7'd0, bus.sel}, 8'h00);
        bus.mem_addr = 16'h0E04;
        #1;
        check("sel_0e04", {7'd0, bus.sel}, 8'h00);
        do_read(16'h7DA4, "mirror_rd", 8'hDF);
        #1;
        check("sel_7da4", {7'd0, bus.sel}, 8'h01);

        // Release: needs three released samples.
        wait_sample();
        press_en = 1'b0;
        wait_sample();
        wait_sample();
        do_read(16'h0D04, "rel_hold", 8'hDF);
        wait_sample();
        do_read(16'h0D04, "rel_done", 8'hFF);

        // Bounce: pressed on alternate frames.
        press_en = 1'b1;
        pat      = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            wait_sample();
            press_en = ~press_en;
            do_read(16'h0D04, "bounce_toggle", 8'hFF);
        end

        // Bounce: differing patterns that never repeat consecutively.
        press_en = 1'b1;
        pat      = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            wait_sample();
            pat = (pat == 4'b1101) ? 4'b1110 : 4'b1101;
            do_read(16'h0D04, "bounce_alt", 8'hFF);
        end
        press_en = 1'b0;
        wait_sample();
        do_read(16'h0D04, "bounce_end", 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
